// File: rtl/serial_source_pkg.sv
// Shared constants, FSM encoding and LFSR helper for the serial traffic source.
// The LFSR helper is only referenced when SERIAL_SOURCE_LFSR_EN is defined.
package serial_source_pkg;

  localparam int SIZE_DEF       = 8;
  localparam int INJ_PERIOD_DEF = 4;
  localparam int THR_W          = 26;
  localparam int SAMPLE_W       = 10;

  localparam logic [SAMPLE_W-1:0] SAMPLE_LAST = '1;

  // x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form: feedback from bits 0,2,3,5.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2
  } tx_state_e;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/serial_source_if.sv
// Link-side signal bundle of the serial source: injection control in,
// serial line and frame counters out.
interface serial_source_if;

  logic                              enable;
  logic                              channel_busy;
  logic                              serial_out;
  logic [serial_source_pkg::THR_W-1:0] throughput;
  logic [serial_source_pkg::THR_W-1:0] flit_count;

  modport master (
    input  enable,
    input  channel_busy,
    output serial_out,
    output throughput,
    output flit_count
  );

  modport slave (
    output enable,
    output channel_busy,
    input  serial_out,
    input  throughput,
    input  flit_count
  );

endinterface

// File: rtl/serial_source_tx_fsm.sv
// Frame serializer: start bit then SIZE data bits LSB first, with a take/pending
// handshake towards the holding register and a done pulse on the last data bit.
module serial_tx_fsm
  import serial_source_pkg::*;
#(
  parameter int SIZE = SIZE_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pending_i,
  input  logic            channel_busy_i,
  input  logic [SIZE-1:0] data_i,
  output logic            take_o,
  output logic            done_o,
  output logic            serial_o
);

  localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SIZE - 1);

  tx_state_e        state_q, state_d;
  logic [SIZE-1:0]  shift_q, shift_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             serial_q, serial_d;
  logic             last_bit;

  assign last_bit = (idx_q == IDX_LAST);
  assign serial_o = serial_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      serial_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      serial_q <= serial_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no branch can infer a latch.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (take_o) begin
          state_d = ST_START;
          shift_d = data_i;
        end
      end
      ST_START: begin
        state_d = ST_DATA;
        idx_d   = '0;
      end
      ST_DATA: begin
        shift_d = shift_q >> 1;
        idx_d   = idx_q + IDX_W'(1);
        if (last_bit) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // channel_busy is only looked at in IDLE; a frame in flight always completes.
  always_comb begin
    serial_d = 1'b0;
    take_o   = 1'b0;
    done_o   = 1'b0;
    unique case (state_q)
      ST_IDLE:  take_o = pending_i && !channel_busy_i;
      ST_START: serial_d = 1'b1;
      ST_DATA: begin
        serial_d = shift_q[0];
        done_o   = last_bit;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/serial_source.sv
// Traffic generator and one-wire transmitter with throughput window and frame counter.
// Define SERIAL_SOURCE_LFSR_EN to take payloads from a 16-bit LFSR instead of a counter.
module serial_source
  import serial_source_pkg::*;
#(
  parameter int SIZE       = SIZE_DEF,
  parameter int INJ_PERIOD = INJ_PERIOD_DEF
) (
  input  logic             clk,
  input  logic             reset,
  serial_source_if.master  bus
);

  localparam int TMR_W = (INJ_PERIOD > 1) ? $clog2(INJ_PERIOD) : 1;
  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(INJ_PERIOD - 1);

  logic [TMR_W-1:0]    timer_q, timer_d;
  logic                pending_q, pending_d;
  logic [SIZE-1:0]     hold_q, hold_d;
  logic [THR_W-1:0]    flit_q, flit_d;
  logic [THR_W-1:0]    running_q, running_d;
  logic [THR_W-1:0]    thr_q, thr_d;
  logic [SAMPLE_W-1:0] sampler_q, sampler_d;
  logic [SIZE-1:0]     payload;
  logic                timer_zero, load, take, done;

`ifdef SERIAL_SOURCE_LFSR_EN
  logic [15:0] lfsr_q, lfsr_d;
  assign payload = lfsr_q[SIZE-1:0];
  assign lfsr_d  = load ? lfsr_next(lfsr_q) : lfsr_q;
`else
  logic [SIZE-1:0] pay_cnt_q, pay_cnt_d;
  assign payload   = pay_cnt_q;
  assign pay_cnt_d = load ? pay_cnt_q + SIZE'(1) : pay_cnt_q;
`endif

  // A load needs an empty holding register, so it can never coincide with a take.
  assign timer_zero = (timer_q == '0);
  assign load       = bus.enable && timer_zero && !pending_q;

  always_comb begin
    timer_d = timer_q;
    if (load)                           timer_d = TMR_RELOAD;
    else if (bus.enable && !timer_zero) timer_d = timer_q - TMR_W'(1);

    pending_d = pending_q;
    if (load)      pending_d = 1'b1;
    else if (take) pending_d = 1'b0;

    hold_d = load ? payload : hold_q;
    flit_d = flit_q + THR_W'(take);

    if (sampler_q == SAMPLE_LAST) begin
      thr_d     = running_q + THR_W'(done);
      running_d = '0;
      sampler_d = '0;
    end else begin
      thr_d     = thr_q;
      running_d = running_q + THR_W'(done);
      sampler_d = sampler_q + SAMPLE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q   <= TMR_RELOAD;
      pending_q <= 1'b0;
      hold_q    <= '0;
      flit_q    <= '0;
      running_q <= '0;
      thr_q     <= '0;
      sampler_q <= '0;
    end else begin
      timer_q   <= timer_d;
      pending_q <= pending_d;
      hold_q    <= hold_d;
      flit_q    <= flit_d;
      running_q <= running_d;
      thr_q     <= thr_d;
      sampler_q <= sampler_d;
    end
  end

`ifdef SERIAL_SOURCE_LFSR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pay_cnt_q <= SIZE'(1);
    else       pay_cnt_q <= pay_cnt_d;
  end
`endif

  serial_tx_fsm #(
    .SIZE (SIZE)
  ) u_tx (
    .clk            (clk),
    .reset          (reset),
    .pending_i      (pending_q),
    .channel_busy_i (bus.channel_busy),
    .data_i         (hold_q),
    .take_o         (take),
    .done_o         (done),
    .serial_o       (bus.serial_out)
  );

  assign bus.flit_count = flit_q;
  assign bus.throughput = thr_q;

endmodule

// File: tb/tb_serial_source.sv
// Scoreboard bench for serial_source: expected payloads are queued by the stimulus,
// a line monitor decodes frames and compares; directed checks cover counters and backpressure.
module tb_serial_source;

  localparam int SIZE       = 8;
  localparam int INJ_PERIOD = 4;
  localparam int N_EXP      = 300;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  serial_source_if bus();

  serial_source #(
    .SIZE       (SIZE),
    .INJ_PERIOD (INJ_PERIOD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int mon_starts = 0;
  int mon_frames = 0;
  logic [SIZE-1:0] exp_q[$];
  logic [SIZE-1:0] exp_tab[N_EXP];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Expected payload sequence after a reset: counter from 1, or the LFSR from its seed.
  task automatic load_expected();
`ifdef SERIAL_SOURCE_LFSR_EN
    logic [15:0] l;
    l = 16'hACE1;
`else
    logic [SIZE-1:0] c;
    c = SIZE'(1);
`endif
    exp_q.delete();
    for (int i = 0; i < N_EXP; i++) begin
`ifdef SERIAL_SOURCE_LFSR_EN
      exp_tab[i] = l[SIZE-1:0];
      l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
`else
      exp_tab[i] = c;
      c = c + SIZE'(1);
`endif
      exp_q.push_back(exp_tab[i]);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_starts(input int target, input int budget, input string name, output int waited);
    waited = 0;
    while (mon_starts < target && waited < budget) begin
      tick(1);
      waited++;
    end
    check(name, 32'(mon_starts >= target), 32'd1);
  endtask

  task automatic wait_frames(input int target, input int budget, input string name);
    int w;
    w = 0;
    while (mon_frames < target && w < budget) begin
      tick(1);
      w++;
    end
    check(name, 32'(mon_frames >= target), 32'd1);
  endtask

  // Line monitor: idle 0, start bit 1, SIZE data bits LSB first, then one idle bit.
  initial begin : p_monitor
    logic [SIZE-1:0] sh;
    int nb;
    bit in_frame;
    bit want_idle;
    sh = '0;
    nb = 0;
    in_frame = 0;
    want_idle = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_frame  = 0;
        want_idle = 0;
      end else if (want_idle) begin
        want_idle = 0;
        check("inter_frame_idle", 32'(bus.serial_out), 32'd0);
      end else if (!in_frame) begin
        if (bus.serial_out) begin
          in_frame = 1;
          nb = 0;
          mon_starts++;
        end
      end else begin
        sh[nb] = bus.serial_out;
        nb++;
        if (nb == SIZE) begin
          in_frame  = 0;
          want_idle = 1;
          mon_frames++;
          if (exp_q.size() == 0) check("exp_queue_depth", 32'(exp_q.size()), 32'd1);
          else                   check("frame_payload", 32'(sh), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin : p_watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : p_stim
    int waited;
    int line_hi;
    int base_s;
    int base_f;
    logic pre_bit;

    bus.enable       = 1'b0;
    bus.channel_busy = 1'b0;
    reset            = 1'b1;
    load_expected();
    tick(3);
    reset = 1'b0;

    check("rst_serial_out", 32'(bus.serial_out), 32'd0);
    check("rst_flit_count", 32'(bus.flit_count), 32'd0);
    check("rst_throughput", 32'(bus.throughput), 32'd0);

    // Injection disabled: the line must stay quiet.
    line_hi = 0;
    repeat (50) begin
      tick(1);
      line_hi += int'(bus.serial_out);
    end
    check("disabled_line_high_cycles", 32'(line_hi), 32'd0);
    check("disabled_flit_count", 32'(bus.flit_count), 32'd0);
    check("disabled_throughput", 32'(bus.throughput), 32'd0);

    // Free-running traffic: frames 0x01, 0x02 back to back at SIZE+2 cycles.
    bus.enable = 1'b1;
    wait_starts(1, 40, "first_start_seen", waited);
    wait_starts(2, 40, "second_start_seen", waited);
    check("frame_period", 32'(waited), 32'(SIZE + 2));
    check("flit_after_second_start", 32'(bus.flit_count), 32'd2);

    // Busy raised on the third data bit of frame 3: frame completes, then the line holds.
    wait_starts(3, 40, "third_start_seen", waited);
    tick(3);
    bus.channel_busy = 1'b1;
    wait_frames(3, 40, "third_frame_complete");
    check("flit_at_busy", 32'(bus.flit_count), 32'd3);
    line_hi = 0;
    repeat (30) begin
      tick(1);
      line_hi += int'(bus.serial_out);
    end
    check("busy_line_high_cycles", 32'(line_hi), 32'd0);
    check("busy_flit_count", 32'(bus.flit_count), 32'd3);
    check("busy_no_new_start", 32'(mon_starts), 32'd3);
    bus.channel_busy = 1'b0;
    wait_starts(4, 10, "resume_start_seen", waited);
    check("resume_start_latency", 32'(waited), 32'd2);
    check("flit_after_resume", 32'(bus.flit_count), 32'd4);

    // Reset while frame 5 is on its third data bit: line drops without a clock edge.
    wait_starts(5, 40, "fifth_start_seen", waited);
    tick(3);
    pre_bit = exp_tab[4][2];
    check("pre_reset_data_bit", 32'(bus.serial_out), 32'(pre_bit));
    reset = 1'b1;
    #1;
    check("async_reset_serial_out", 32'(bus.serial_out), 32'd0);
    check("async_reset_flit_count", 32'(bus.flit_count), 32'd0);
    check("async_reset_throughput", 32'(bus.throughput), 32'd0);
    tick(2);
    load_expected();
    tick(1);
    reset = 1'b0;

    base_s = mon_starts;
    base_f = mon_frames;
    wait_starts(base_s + 1, 40, "post_reset_start_seen", waited);
    wait_frames(base_f + 1, 40, "post_reset_frame_complete");
    check("post_reset_flit_count", 32'(bus.flit_count), 32'd1);

    // Continuous traffic past two full 1024-cycle windows.
    tick(2100);
    check_range("throughput_window", int'(bus.throughput), 102, 103);
    check_range("flit_count_continuous", int'(bus.flit_count), 205, 215);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
